// File: rtl/led_chain_driver_pkg.sv
// Shared definitions for led_chain_driver: sequencer state type and board defaults.
package led_drv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_LATCH,
    S_HOLD
  } drv_state_t;

  localparam int unsigned CLOCK_5_HZ = 5000000;
  // 40 ms display hold at CLOCK_5
  localparam int unsigned HOLD_40MS  = CLOCK_5_HZ / 25;

endpackage

// File: rtl/led_chain_driver_if.sv
// Control/pin bundle between display logic (master) and led_chain_driver (slave).
interface led_chain_driver_if #(
  parameter int BITS     = 8,
  parameter int PWM_BITS = 4
);
  logic                start;
  logic [BITS-1:0]     data;
  logic [PWM_BITS-1:0] brightness;
  logic                busy;
  logic                done;
  logic                sdi;
  logic                sclk;
  logic                latch;
  logic                n_output_enable;

  modport master (
    output start, data, brightness,
    input  busy, done, sdi, sclk, latch, n_output_enable
  );

  modport slave (
    input  start, data, brightness,
    output busy, done, sdi, sclk, latch, n_output_enable
  );
endinterface

// File: rtl/led_chain_driver_pwm.sv
// led_pwm: free-running brightness counter with active-low compare output.
// Used by led_chain_driver only when LED_CHAIN_PWM_EN is defined.
module led_pwm #(
  parameter int PWM_BITS = 4
) (
  input  logic                CLOCK_5,
  input  logic                reset,
  input  logic                clear,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] level,
  output logic                n_out
);
  logic [PWM_BITS-1:0] r_cnt;

  always_ff @(posedge CLOCK_5 or posedge reset) begin
    if (reset)       r_cnt <= '0;
    else if (clear)  r_cnt <= '0;
    else if (enable) r_cnt <= r_cnt + PWM_BITS'(1);
  end

  // level of all-ones keeps the output enabled on every count
  assign n_out = !(r_cnt <= level);
endmodule

// File: rtl/led_chain_driver.sv
// led_chain_driver: captures a chain frame, shifts it out on SDI/SCLK, latches, then holds nOE low.
// Define LED_CHAIN_PWM_EN to modulate nOE with the captured brightness during display.
module led_chain_driver
  import led_drv_pkg::*;
#(
  parameter int NUM_DEVICES = 1,
  parameter int CLK_DIV     = 1,
  parameter int HOLD_TICKS  = HOLD_40MS,
  parameter int PWM_BITS    = 4
) (
  input  logic              CLOCK_5,
  input  logic              reset,
  led_chain_driver_if.slave bus
);
  localparam int BITS     = 8 * NUM_DEVICES;
  localparam int HOLD_EFF = (HOLD_TICKS < 1) ? 1 : HOLD_TICKS;
  localparam int HW       = $clog2(HOLD_EFF + 1);
  localparam int BW       = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(BITS - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_EFF - 1);

  drv_state_t      r_state, w_state_n;
  logic [BITS-1:0] r_shift, w_shift_n;
  logic [BW-1:0]   r_bit_cnt, w_bit_cnt_n, w_bit_next;
  logic [DW-1:0]   r_div_cnt, w_div_cnt_n;
  logic [HW-1:0]   r_hold_cnt, w_hold_cnt_n;
  logic            r_frame_valid, w_valid_n;
  logic            r_sdi, w_sdi_n;
  logic            r_sclk, w_sclk_n;
  logic            r_latch, w_latch_n;
  logic            r_busy, w_busy_n;
  logic            r_done, w_done_n;
  logic            r_noe, w_noe_n;
  logic            w_accept;
  logic            w_div_end;
  logic            w_on_noe;

  assign w_div_end  = (r_div_cnt == DIV_LAST);
  assign w_bit_next = r_bit_cnt + BW'(1);

  // Outputs are registered from the next-state decode so each one is aligned with its state.
  always_comb begin
    w_state_n    = r_state;
    w_shift_n    = r_shift;
    w_bit_cnt_n  = r_bit_cnt;
    w_div_cnt_n  = r_div_cnt;
    w_hold_cnt_n = r_hold_cnt;
    w_valid_n    = r_frame_valid;
    w_sdi_n      = r_sdi;
    w_sclk_n     = 1'b0;
    w_latch_n    = 1'b0;
    w_busy_n     = r_busy;
    w_done_n     = 1'b0;
    w_noe_n      = r_noe;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_noe_n = r_frame_valid ? w_on_noe : 1'b1;
        if (bus.start) begin
          w_accept    = 1'b1;
          w_shift_n   = bus.data;
          w_bit_cnt_n = '0;
          w_div_cnt_n = '0;
          w_busy_n    = 1'b1;
          w_noe_n     = 1'b1;
          w_sdi_n     = bus.data[0];
          w_state_n   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (w_div_end) begin
          w_div_cnt_n = '0;
          w_sclk_n    = 1'b1;
          w_state_n   = S_HIGH;
        end else begin
          w_div_cnt_n = r_div_cnt + DW'(1);
        end
      end
      S_HIGH: begin
        if (w_div_end) begin
          w_div_cnt_n = '0;
          w_state_n   = S_LOW;
        end else begin
          w_sclk_n    = 1'b1;
          w_div_cnt_n = r_div_cnt + DW'(1);
        end
      end
      S_LOW: begin
        if (!w_div_end) begin
          w_div_cnt_n = r_div_cnt + DW'(1);
        end else if (r_bit_cnt == BIT_LAST) begin
          w_div_cnt_n = '0;
          w_sdi_n     = 1'b0;
          w_latch_n   = 1'b1;
          w_state_n   = S_LATCH;
        end else begin
          w_div_cnt_n = '0;
          w_bit_cnt_n = w_bit_next;
          w_sdi_n     = r_shift[w_bit_next];
          w_state_n   = S_SETUP;
        end
      end
      S_LATCH: begin
        if (w_div_end) begin
          w_div_cnt_n  = '0;
          w_valid_n    = 1'b1;
          w_hold_cnt_n = '0;
          w_noe_n      = w_on_noe;
          w_state_n    = S_HOLD;
        end else begin
          w_latch_n   = 1'b1;
          w_div_cnt_n = r_div_cnt + DW'(1);
        end
      end
      S_HOLD: begin
        w_noe_n = w_on_noe;
        if (r_hold_cnt == HOLD_LAST) begin
          w_done_n  = 1'b1;
          w_busy_n  = 1'b0;
          w_state_n = S_IDLE;
        end else begin
          w_hold_cnt_n = r_hold_cnt + HW'(1);
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_5 or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_div_cnt     <= '0;
      r_hold_cnt    <= '0;
      r_frame_valid <= 1'b0;
      r_sdi         <= 1'b0;
      r_sclk        <= 1'b0;
      r_latch       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_noe         <= 1'b1;
    end else begin
      r_state       <= w_state_n;
      r_shift       <= w_shift_n;
      r_bit_cnt     <= w_bit_cnt_n;
      r_div_cnt     <= w_div_cnt_n;
      r_hold_cnt    <= w_hold_cnt_n;
      r_frame_valid <= w_valid_n;
      r_sdi         <= w_sdi_n;
      r_sclk        <= w_sclk_n;
      r_latch       <= w_latch_n;
      r_busy        <= w_busy_n;
      r_done        <= w_done_n;
      r_noe         <= w_noe_n;
    end
  end

`ifdef LED_CHAIN_PWM_EN
  logic [PWM_BITS-1:0] r_brightness;
  logic                w_pwm_n;
  logic                w_pwm_en;

  always_ff @(posedge CLOCK_5 or posedge reset) begin
    if (reset)         r_brightness <= '0;
    else if (w_accept) r_brightness <= bus.brightness;
  end

  // Counter advances with the state being entered so the first display cycle compares count 0.
  assign w_pwm_en = (w_state_n == S_HOLD) || ((w_state_n == S_IDLE) && w_valid_n);

  led_pwm #(.PWM_BITS(PWM_BITS)) u_pwm (
    .CLOCK_5 (CLOCK_5),
    .reset   (reset),
    .clear   (w_accept),
    .enable  (w_pwm_en),
    .level   (r_brightness),
    .n_out   (w_pwm_n)
  );

  assign w_on_noe = w_pwm_n;
`else
  logic [PWM_BITS-1:0] w_unused_brightness;
  assign w_unused_brightness = bus.brightness;
  assign w_on_noe            = 1'b0;
`endif

  assign bus.sdi             = r_sdi;
  assign bus.sclk            = r_sclk;
  assign bus.latch           = r_latch;
  assign bus.busy            = r_busy;
  assign bus.done            = r_done;
  assign bus.n_output_enable = r_noe;
endmodule

// File: doc/led_chain_driver.md
Name: led_chain_driver

Overview:
- Serial driver for a daisy-chain of NUM_DEVICES 8-bit shift-register LED drivers (595-style: SDI/SCLK/LATCH/nOE).
- Captures a full-chain frame on a start/busy/done handshake and shifts it out with a divided, registered SCLK.
- Pulses LATCH, then enables the outputs for a programmable hold window with optional PWM brightness.
- Sits between the display/control logic and the board LED pins, in the CLOCK_5 domain.

Parameters:
- NUM_DEVICES, 1, number of cascaded 8-bit registers; localparam BITS = 8*NUM_DEVICES.
- CLK_DIV, 1, CLOCK_5 cycles per SCLK phase (setup/high/low); legal range >= 1.
- HOLD_TICKS, 200000, CLOCK_5 cycles in HOLD (40 ms at 5 MHz); a value of 0 is treated as 1.
- PWM_BITS, 4, brightness width.

Ports:
- CLOCK_5  in  1  5 MHz system clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  frame request; sampled only in IDLE.
- data  in  BITS  frame; data[0] shifted first; captured on the accepted start cycle.
- brightness  in  PWM_BITS  duty select; captured with data.
- busy  out  1  high from accept until done.
- done  out  1  one-cycle pulse at end of HOLD.
- sdi  out  1  serial data.
- sclk  out  1  serial clock; registered, never gated from CLOCK_5.
- latch  out  1  storage-register strobe.
- n_output_enable  out  1  active-low output enable.

Behaviour:
- Reset: clock domain is CLOCK_5; reset is asynchronous, active-high. Outputs go immediately to sdi=0, sclk=0, latch=0, busy=0, done=0, n_output_enable=1. Internally: state=IDLE, frame_valid=0, counters=0.
- All outputs are registered.
- IDLE:
  - On start=1: capture data into shift_reg, capture brightness, bit_cnt=0, div_cnt=0, busy<=1, n_output_enable<=1, go to SETUP.
  - Otherwise n_output_enable = !frame_valid (no-PWM build) or the PWM output (PWM build).
- SETUP: sdi<=shift_reg[bit_cnt], sclk=0. Stay CLK_DIV cycles, then HIGH.
- HIGH: sclk=1 for CLK_DIV cycles, then LOW.
- LOW: sclk=0 for CLK_DIV cycles.
  - If bit_cnt==BITS-1: go to LATCH with sdi<=0.
  - Else: bit_cnt+1, go to SETUP.
- LATCH: latch=1 for CLK_DIV cycles, then latch<=0, frame_valid<=1, hold_cnt=0, go to HOLD.
- HOLD:
  - Outputs enabled (see Optional Feature). hold_cnt increments each cycle.
  - At hold_cnt==HOLD_TICKS-1: done<=1 for one cycle, busy<=0, go to IDLE.
- Timing:
  - Bit period is 3*CLK_DIV.
  - Accept-to-latch-rise is BITS*3*CLK_DIV cycles.
  - Frame length is BITS*3*CLK_DIV + CLK_DIV + HOLD_TICKS cycles, plus 1 for the accept cycle.
- Handshake:
  - start while busy=1 is ignored, not queued.
  - start held high at the done cycle is sampled in the following IDLE cycle, giving back-to-back frames with exactly one IDLE cycle between them.
  - data/brightness changes after accept have no effect on the frame in flight.
- Counter widths: hold_cnt is clog2(HOLD_TICKS+1) bits, bit_cnt is clog2(BITS) bits (minimum 1), div_cnt is clog2(CLK_DIV) bits (minimum 1). No wrap beyond terminal values.
- Reset mid-frame: outputs return to reset values the same instant, and the partially shifted frame is discarded. Because latch is never pulsed, the LED registers keep the previous frame; nOE stays high until a new frame completes.

Optional Feature:
- Macro: LED_CHAIN_PWM_EN.
- Defined:
  - A free-running PWM_BITS counter runs in HOLD and in IDLE with frame_valid=1.
  - n_output_enable = !(pwm_cnt <= brightness_q): all-ones gives 100%; 0 gives 1/2^PWM_BITS.
  - The counter is cleared on accept.
- Undefined:
  - brightness is ignored (no capture register).
  - n_output_enable = 0 throughout HOLD and in IDLE when frame_valid=1; 1 otherwise.

Decomposition:
- Package led_drv_pkg:
  - state encoding localparams (IDLE, SETUP, HIGH, LOW, LATCH, HOLD);
  - default constants CLOCK_5_HZ=5000000 and HOLD_40MS=200000.
- One sub-module, led_pwm: counter plus compare, parameter PWM_BITS; ports CLOCK_5, reset, clear, enable, level, n_out. Instantiated only under LED_CHAIN_PWM_EN.

Test Plan:
- Reset values: NUM_DEVICES=1, CLK_DIV=1, HOLD_TICKS=10, start with data=8'hA5 -> sdi sampled at 8 sclk rising edges = 1,0,1,0,0,1,0,1. One latch pulse 1 cycle wide, 24 cycles after accept. done 10 cycles after latch falls. Outputs at reset values before start.
- Chain/divider: NUM_DEVICES=2, CLK_DIV=3, data=16'h8001 -> exactly 16 sclk pulses, each 3 cycles high. sdi=1 on pulses 1 and 16 only. Accept-to-latch = 144 cycles.
- Handshake: start pulsed mid-shift with different data -> ignored, frame unchanged, one done. start held constantly -> done, one IDLE cycle, busy re-asserted.
- Async reset: reset asserted mid-shift at bit 5 -> sclk, sdi, busy go to 0 and n_output_enable to 1 without waiting for a clock edge. latch is never pulsed. The next frame completes normally.
- PWM (LED_CHAIN_PWM_EN, PWM_BITS=4): brightness=4'd3 -> n_output_enable low 4 of every 16 cycles in HOLD. brightness=4'hF -> low continuously. Without the macro -> low for all of HOLD regardless of brightness.
- Edge parameter: HOLD_TICKS=0 -> HOLD lasts exactly 1 cycle, done pulse width 1.
